uart_tx_fifo_tx: RTL and testbench

Buffered 8N1 UART transmitter, the transmit-side counterpart of the team's UART receiver; both use the same fixed-clock bit period. Bytes are written into a small internal FIFO through a single-cycle strobe and serialized LSB-first on `TX` with one start bit and one stop bit. Frames go out back-to-back while the FIFO holds data. A per-byte completion pulse is provided for the command and readback logic upstream.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo_tx_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx_fifo_tx.sv | 67 ++++++
 tb/tb_uart_tx_fifo_tx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int UART_BAUD_DIV_DEFAULT = 44;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_fifo_tx_if.sv
// uart_tx_fifo_tx_if: byte-write and serial-line bundle of the buffered transmitter
interface uart_tx_fifo_tx_if;
  import uart_pkg::*;
  logic trmt;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic full;
  logic idle;
  logic TX;
  logic tx_done;
  modport master (output trmt, tx_data, input full, idle, TX, tx_done);
  modport slave (input trmt, tx_data, output full, idle, TX, tx_done);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through byte FIFO; writes while full are dropped
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic push_ok, pop_ok;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rd];
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  always_ff @(posedge clk)
    if (push_ok) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + AW'(push_ok);
      rd <= rd + AW'(pop_ok);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/uart_tx_fifo_tx.sv
// uart_tx_fifo_tx: buffered 8N1 transmitter sending queued bytes back-to-back
module uart_tx_fifo_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  uart_tx_fifo_tx_if.slave bus
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
  tx_state_t state, nxt;
  logic [BW-1:0] baud;
  logic [3:0] bit_cnt;
  logic [UART_DATA_BITS-1:0] shift, dout;
  logic empty, full, pop, bdone;
  logic tx_nxt, done_nxt, idle_nxt;
  logic tx_q, done_q, idle_q;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.trmt),
    .pop(pop),
    .din(bus.tx_data),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  assign bus.full = full;
  assign bus.TX = tx_q;
  assign bus.tx_done = done_q;
  assign bus.idle = idle_q;
  assign bdone = baud == B_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (empty ? IDLE : START)
        : state == START ? (bdone ? DATA : START)
        : state == DATA  ? ((bdone && bit_cnt == 4'(UART_DATA_BITS - 1)) ? STOP : DATA)
        : bdone ? (empty ? IDLE : START) : STOP;
  // popping from STOP lets the next start bit follow the stop bit with no gap
  always_comb begin
    pop = !empty && (state == IDLE || (state == STOP && bdone));
    tx_nxt = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    done_nxt = state == STOP && bdone;
    idle_nxt = state == IDLE && empty;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      baud <= (state == IDLE || bdone) ? '0 : baud + 1'b1;
      bit_cnt <= state == START ? '0 : (state == DATA && bdone) ? bit_cnt + 1'b1 : bit_cnt;
      shift <= pop ? dout : (state == DATA && bdone) ? shift >> 1 : shift;
      tx_q <= tx_nxt;
      done_q <= done_nxt;
      idle_q <= idle_nxt;
    end
endmodule

// File: tb/tb_uart_tx_fifo_tx.sv
// tb_uart_tx_fifo_tx: timing-level reference model, line receiver and directed/random stimulus
module tb_uart_tx_fifo_tx;
  localparam int B = 44;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  uart_tx_fifo_tx_if bus();
  uart_tx_fifo_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // model: byte q queues, frame popped at edge p drives the line from p+1 for 10*B cycles
  logic [7:0] q[$];
  logic [7:0] acc[$];
  logic [7:0] fbyte = 8'h00;
  logic [9:0] mframe;
  int last_p = 0;
  bit lp_v = 0;
  int md;
  bit mpop, mfull;
  int accepted = 0;
  logic e_tx = 1'b1, e_done = 1'b0, e_idle = 1'b1, e_full = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      acc.delete();
      lp_v = 0;
      e_tx = 1'b1;
      e_done = 1'b0;
      e_idle = 1'b1;
      e_full = 1'b0;
    end else begin
      cyc++;
      md = cyc - last_p;
      mframe = {1'b1, fbyte, 1'b0};
      e_tx = (lp_v && md >= 1 && md <= 10 * B) ? mframe[(md - 1) / B] : 1'b1;
      e_done = lp_v && md == 10 * B;
      e_idle = (!lp_v || md > 10 * B) && q.size() == 0;
      mpop = q.size() > 0 && (!lp_v || md >= 10 * B);
      mfull = q.size() == D;
      if (mpop) begin
        fbyte = q.pop_front();
        last_p = cyc;
        lp_v = 1;
      end
      if (bus.trmt && !mfull) begin
        q.push_back(bus.tx_data);
        acc.push_back(bus.tx_data);
        accepted++;
      end
      e_full = q.size() == D;
    end
  end
  int done_cnt = 0;
  always @(negedge clk) begin
    chk("tx", bus.TX, e_tx);
    chk("tx_done", bus.tx_done, e_done);
    chk("idle", bus.idle, e_idle);
    chk("full", bus.full, e_full);
    if (bus.tx_done) done_cnt++;
  end
  // receiver samples mid-bit and checks bytes in push order
  bit rx_busy = 0;
  int rx_c = 0;
  int rx_cnt = 0;
  logic [9:0] rx_sh;
  logic [7:0] rx_exp;
  logic [7:0] rx_log[$];
  always @(negedge clk or posedge rst) begin
    if (rst) rx_busy = 0;
    else if (!rx_busy) begin
      if (bus.TX === 1'b0) begin
        rx_busy = 1;
        rx_c = 0;
      end
    end else begin
      rx_c++;
      if (rx_c % B == B / 2) rx_sh[rx_c / B] = bus.TX;
      if (rx_c == 9 * B + B / 2) begin
        rx_busy = 0;
        rx_exp = acc.size() > 0 ? acc.pop_front() : 8'hxx;
        chk("rx_stop", rx_sh[9], 1'b1);
        chk("rx_byte", rx_sh[8:1], rx_exp);
        rx_log.push_back(rx_sh[8:1]);
        rx_cnt++;
      end
    end
  end
  task automatic at_cyc(input int t);
    repeat (t - cyc) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] b, output int e);
    bus.trmt = 1'b1;
    bus.tx_data = b;
    e = cyc + 1;
    @(negedge clk);
    bus.trmt = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 5000 && !(bus.idle && q.size() == 0 && !rx_busy); i++) @(negedge clk);
    chk("idle_timeout", bus.idle, 1'b1);
    repeat (2) @(negedge clk);
  endtask
  int e0, e1, e2, e3, et, d0, target, base;
  logic [9:0] pat;
  logic [7:0] exp5 [5];
  initial begin
    bus.trmt = 1'b0;
    bus.tx_data = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.TX, 1'b1);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_done", bus.tx_done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push(8'hA5, e0);
    pat = 10'b1_1010_0101_0;
    at_cyc(e0 + 1);
    chk("a5_e1_tx", bus.TX, 1'b1);
    at_cyc(e0 + 2);
    chk("a5_start_edge", bus.TX, 1'b0);
    for (int k = 0; k < 10; k++) begin
      at_cyc(e0 + 2 + k * B + B / 2);
      chk("a5_bit", bus.TX, pat[k]);
    end
    at_cyc(e0 + 2 + 438);
    chk("a5_done_early", bus.tx_done, 1'b0);
    at_cyc(e0 + 2 + 439);
    chk("a5_done", bus.tx_done, 1'b1);
    at_cyc(e0 + 2 + 441);
    chk("a5_idle", bus.idle, 1'b1);
    wait_idle();
    push(8'h55, e1);
    push(8'h0F, et);
    at_cyc(e1 + 2 + 439);
    chk("b2b_done1", bus.tx_done, 1'b1);
    at_cyc(e1 + 2 + 440);
    chk("b2b_start2", bus.TX, 1'b0);
    at_cyc(e1 + 2 + 879);
    chk("b2b_done2", bus.tx_done, 1'b1);
    wait_idle();
    push(8'hEE, e2);
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), et);
      chk("ovf_full", bus.full, i >= 4);
    end
    at_cyc(e2 + 10 * B);
    push(8'h99, et);
    chk("pop_drop_full", bus.full, 1'b0);
    wait_idle();
    exp5 = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04};
    base = rx_log.size() - 5;
    for (int i = 0; i < 5; i++) chk("ovf_rx", rx_log[base + i], exp5[i]);
    push(8'h3C, e3);
    at_cyc(e3 + 2 + 4 * B + 10);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_tx", bus.TX, 1'b1);
    chk("rst_mid_done", bus.tx_done, 1'b0);
    chk("rst_mid_idle", bus.idle, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (1000) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, d0);
    target = accepted + 128;
    for (int i = 0; i < 70000 && accepted < target; i++) begin
      bus.trmt = $urandom_range(0, 63) == 0;
      bus.tx_data = 8'($urandom);
      @(negedge clk);
    end
    bus.trmt = 1'b0;
    chk("rand_push_timeout", accepted >= target, 1'b1);
    wait_idle();
    chk("done_vs_rx", done_cnt, rx_cnt);
    chk("acc_left", acc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
